// File: rtl/redun_carry_resolve_if.sv
// Handshake bundle for the redundant-to-binary carry resolver.
// The master drives the redundant word and downstream ready; the slave returns the result.
interface redun_carry_resolve_if #(
  parameter int WRD_BITS = 32,
  parameter int NUM_WRDS = 33
);
  localparam int DAT_BITS = NUM_WRDS * WRD_BITS;
  localparam int IN_BITS  = NUM_WRDS * (WRD_BITS + 1);

  logic [IN_BITS-1:0]  i_dat;
  logic                i_val;
  logic                o_rdy;
  logic [DAT_BITS-1:0] o_dat;
  logic                o_ovf;
  logic                o_val;
  logic                i_rdy;

  modport master (
    output i_dat,
    output i_val,
    input  o_rdy,
    input  o_dat,
    input  o_ovf,
    input  o_val,
    output i_rdy
  );

  modport slave (
    input  i_dat,
    input  i_val,
    output o_rdy,
    output o_dat,
    output o_ovf,
    output o_val,
    input  i_rdy
  );
endinterface

// File: rtl/redun_carry_resolve.sv
// Word-serial carry propagation of a redundant residue into canonical binary.
// One word per clock; overflow is the carry out of the top word.
module redun_carry_resolve #(
  parameter int WRD_BITS = 32,
  parameter int NUM_WRDS = 33
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  redun_carry_resolve_if.slave bus
);
  localparam int DAT_BITS = NUM_WRDS * WRD_BITS;
  localparam int RW       = WRD_BITS + 1;
  localparam int IN_BITS  = NUM_WRDS * RW;
  localparam int IDXW     = (NUM_WRDS > 1) ? $clog2(NUM_WRDS + 1) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_WRDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PROP,
    DONE
  } state_t;

  state_t              state_q;
  logic [IDXW-1:0]     idx_q;
  logic [1:0]          carry_q;
  logic [IN_BITS-1:0]  cap_q;
  logic [DAT_BITS-1:0] dat_q;
  logic                ovf_q;
  logic                val_q;
  logic [WRD_BITS+1:0] sum;

  // Capture is shifted down one word per cycle, so the live word is always at the bottom.
  always_comb begin
    sum = {1'b0, cap_q[RW-1:0]}
        + {{WRD_BITS{1'b0}}, carry_q};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= '0;
      cap_q   <= '0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_val) begin
            cap_q   <= bus.i_dat;
            idx_q   <= '0;
            carry_q <= '0;
            state_q <= PROP;
          end
        end
        PROP: begin
          dat_q[idx_q*WRD_BITS +: WRD_BITS] <= sum[WRD_BITS-1:0];
          carry_q <= sum[WRD_BITS+1:WRD_BITS];
          cap_q   <= cap_q >> RW;
          idx_q   <= idx_q + IDXW'(1);
          if (idx_q == LAST) begin
            ovf_q   <= |sum[WRD_BITS+1:WRD_BITS];
            val_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.i_rdy) begin
            val_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_rdy = (state_q == IDLE);
  assign bus.o_val = val_q;
  assign bus.o_dat = dat_q;
  assign bus.o_ovf = ovf_q;
endmodule

// File: tb/tb_redun_carry_resolve.sv
// Directed and random checks of redun_carry_resolve against an arithmetic model.
// The model sums weighted words as one wide integer.
module tb_redun_carry_resolve;
  localparam int W  = 32;
  localparam int N  = 33;
  localparam int D  = W * N;
  localparam int IW = N * (W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  redun_carry_resolve_if #(.WRD_BITS(W), .NUM_WRDS(N)) bus ();

  redun_carry_resolve #(.WRD_BITS(W), .NUM_WRDS(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [D+1:0] ref_val(input logic [IW-1:0] din);
    logic [D+1:0] acc;
    logic [D+1:0] t;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      t = '0;
      t[W:0] = din[i*(W+1) +: W+1];
      acc = acc + (t << (i * W));
    end
    return acc;
  endfunction

  function automatic logic [IW-1:0] rnd_vec();
    logic [IW-1:0] v;
    logic [W:0]    w;
    v = '0;
    for (int i = 0; i < N; i++) begin
      case ($urandom % 4)
        0:       w = {1'($urandom & 1), 32'($urandom)};
        1:       w = 33'h1_FFFF_FFFF;
        2:       w = 33'h0_FFFF_FFFF;
        default: w = '0;
      endcase
      v[i*(W+1) +: W+1] = w;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [D-1:0] obs,
                      input logic [D-1:0] exp);
    int k;
    tests++;
    assert (obs === exp) else begin
      fails++;
      k = 0;
      for (int j = N - 1; j >= 0; j--)
        if (obs[j*W +: W] !== exp[j*W +: W]) k = j;
      $error("FAIL %s: word %0d got %h want %h", tag, k,
             obs[k*W +: W], exp[k*W +: W]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [IW-1:0] din, input logic [D-1:0] edat,
                     input logic eovf, input int hold, input string tag);
    int            lat;
    logic          r;
    logic          busy_ok;
    logic          stab;
    logic [D-1:0]  sd;
    logic          so;
    bus.i_dat = din;
    bus.i_val = 1'b1;
    lat = 0;
    do begin
      r = bus.o_rdy;
      step();
      lat++;
    end while (!r && lat < 100);
    chk({tag, ":accept"}, 64'(r), 64'(1));
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.o_val && lat < 100) begin
      busy_ok &= (bus.o_rdy === 1'b0);
      bus.i_val = 1'($urandom & 1);
      bus.i_dat = ~din;
      bus.i_rdy = 1'($urandom & 1);
      step();
      lat++;
    end
    chk({tag, ":latency"}, 64'(lat), 64'(N));
    chk({tag, ":rdy_busy"}, 64'(busy_ok), 64'(1));
    chkd({tag, ":dat"}, bus.o_dat, edat);
    chk({tag, ":ovf"}, 64'(bus.o_ovf), 64'(eovf));
    sd = bus.o_dat;
    so = bus.o_ovf;
    stab = 1'b1;
    for (int k = 0; k < hold; k++) begin
      bus.i_rdy = 1'b0;
      bus.i_val = 1'b1;
      bus.i_dat = rnd_vec();
      step();
      stab &= (bus.o_val === 1'b1) && (bus.o_dat === sd) &&
              (bus.o_ovf === so) && (bus.o_rdy === 1'b0);
    end
    chk({tag, ":hold"}, 64'(stab), 64'(1));
    bus.i_rdy = 1'b1;
    step();
    bus.i_rdy = 1'b0;
    bus.i_val = 1'b0;
    chk({tag, ":rel_val"}, 64'(bus.o_val), 64'(0));
    chk({tag, ":rel_rdy"}, 64'(bus.o_rdy), 64'(1));
    chkd({tag, ":keep"}, bus.o_dat, sd);
  endtask

  initial begin
    logic [IW-1:0]  v;
    logic [D-1:0]   e;
    logic [D+1:0]   m;
    bus.i_dat = '0;
    bus.i_val = 1'b0;
    bus.i_rdy = 1'b0;
    repeat (3) step();
    chk("rst_rdy", 64'(bus.o_rdy), 64'(1));
    chk("rst_val", 64'(bus.o_val), 64'(0));
    chk("rst_ovf", 64'(bus.o_ovf), 64'(0));
    chkd("rst_dat", bus.o_dat, '0);
    rst_n = 1'b1;
    step();

    txn('0, '0, 1'b0, 0, "zero");

    v = '0;
    v[0 +: W+1] = 33'h1_0000_0000;
    for (int i = 1; i < 32; i++) v[i*(W+1) +: W+1] = 33'h0_FFFF_FFFF;
    e = '0;
    e[32*W +: W] = 32'h1;
    txn(v, e, 1'b0, 1, "ripple");

    for (int i = 0; i < N; i++) v[i*(W+1) +: W+1] = 33'h1_FFFF_FFFF;
    e = '0;
    e[0 +: W] = 32'hFFFF_FFFF;
    for (int i = 2; i < N; i++) e[i*W +: W] = 32'h1;
    txn(v, e, 1'b1, 10, "carry2");

    v = '0;
    v[32*(W+1) +: W+1] = 33'h1_0000_0000;
    txn(v, '0, 1'b1, 2, "pureovf");

    v = rnd_vec();
    bus.i_dat = v;
    bus.i_val = 1'b1;
    step();
    bus.i_val = 1'b0;
    chk("rstmid_busy", 64'(bus.o_rdy), 64'(0));
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("rstmid_val", 64'(bus.o_val), 64'(0));
    chk("rstmid_ovf", 64'(bus.o_ovf), 64'(0));
    chk("rstmid_rdy", 64'(bus.o_rdy), 64'(1));
    chkd("rstmid_dat", bus.o_dat, '0);
    step();
    rst_n = 1'b1;
    step();
    chk("rstrel_rdy", 64'(bus.o_rdy), 64'(1));
    chk("rstrel_val", 64'(bus.o_val), 64'(0));

    v = rnd_vec();
    m = ref_val(v);
    txn(v, m[D-1:0], |m[D+1:D], 0, "postrst");

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom % 3) step();
      v = rnd_vec();
      m = ref_val(v);
      txn(v, m[D-1:0], |m[D+1:D], int'($urandom % 4), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
